regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback.sv | 126 ++++++++++++
 tb/tb_regfile_writeback.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Register-file writeback arbiter: single-cycle ALU results win over a FIFO of long-latency
// results, plus a busy scoreboard. Optional forwarding port enabled by WB_FORWARD_EN.
module regfile_writeback #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic [31:0] busy,
    output logic        rf_write_enable,
    output logic [4:0]  rf_write_address,
    output logic [31:0] rf_write_data
`ifdef WB_FORWARD_EN
    ,
    input  logic [4:0]  fwd_address,
    output logic        fwd_hit,
    output logic [31:0] fwd_data
`endif
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(FIFO_DEPTH);

    logic [4:0]  fifo_rd_q   [FIFO_DEPTH];
    logic [31:0] fifo_data_q [FIFO_DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic [31:0]     busy_q, busy_d;
    logic            we_q, we_d;
    logic [4:0]      wa_q, wa_d;
    logic [31:0]     wd_q, wd_d;

    logic        a_sel, push, pop;
    logic [4:0]  head_rd;
    logic [31:0] head_data;
    logic [31:0] set_mask, clr_mask;

    // b_ready looks only at registered occupancy, so a same-cycle pop cannot raise it.
    assign b_ready = (count_q < DepthCnt);

    always_comb begin
        a_sel     = a_valid && (a_rd != 5'd0);
        push      = b_valid && b_ready;
        pop       = !a_sel && (count_q != '0);
        head_rd   = fifo_rd_q[rd_ptr_q];
        head_data = fifo_data_q[rd_ptr_q];

        we_d = 1'b0;
        wa_d = wa_q;
        wd_d = wd_q;
        if (a_sel) begin
            we_d = 1'b1;
            wa_d = a_rd;
            wd_d = a_data;
        end else if (pop && (head_rd != 5'd0)) begin
            we_d = 1'b1;
            wa_d = head_rd;
            wd_d = head_data;
        end

        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase

        // Set is applied after clear so a simultaneous reserve wins.
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid && (issue_rd != 5'd0)) set_mask[issue_rd] = 1'b1;
        if (pop && (head_rd != 5'd0)) clr_mask[head_rd] = 1'b1;
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= b_rd;
            fifo_data_q[wr_ptr_q] <= b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            we_q     <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            we_q     <= we_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
        end
    end

    assign busy             = busy_q;
    assign rf_write_enable  = we_q;
    assign rf_write_address = wa_q;
    assign rf_write_data    = wd_q;

`ifdef WB_FORWARD_EN
    assign fwd_hit  = we_q && (fwd_address != 5'd0) && (wa_q == fwd_address);
    assign fwd_data = wd_q;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed, table-driven bench for regfile_writeback: each record holds one cycle of inputs
// and the registered outputs expected just after that rising edge.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] busy;
    logic        rf_write_enable;
    logic [4:0]  rf_write_address;
    logic [31:0] rf_write_data;
`ifdef WB_FORWARD_EN
    logic [4:0]  fwd_address = 5'd0;
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_writeback #(.FIFO_DEPTH(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .a_valid          (a_valid),
        .a_rd             (a_rd),
        .a_data           (a_data),
        .b_valid          (b_valid),
        .b_ready          (b_ready),
        .b_rd             (b_rd),
        .b_data           (b_data),
        .issue_valid      (issue_valid),
        .issue_rd         (issue_rd),
        .busy             (busy),
        .rf_write_enable  (rf_write_enable),
        .rf_write_address (rf_write_address),
        .rf_write_data    (rf_write_data)
`ifdef WB_FORWARD_EN
        ,
        .fwd_address      (fwd_address),
        .fwd_hit          (fwd_hit),
        .fwd_data         (fwd_data)
`endif
    );

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  brd;
        logic [31:0] bd;
        logic        iv;
        logic [4:0]  ird;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        brdy;
        logic [31:0] bsy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic av, logic [4:0] ard, logic [31:0] ad,
                                logic bv, logic [4:0] brd, logic [31:0] bd,
                                logic iv, logic [4:0] ird, logic we, logic [4:0] wa,
                                logic [31:0] wd, logic brdy, logic [31:0] bsy);
        vec_t v;
        v.rst = rst; v.av = av; v.ard = ard; v.ad = ad;
        v.bv = bv; v.brd = brd; v.bd = bd; v.iv = iv; v.ird = ird;
        v.we = we; v.wa = wa; v.wd = wd; v.brdy = brdy; v.bsy = bsy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; a_valid = v.av; a_rd = v.ard; a_data = v.ad;
        b_valid = v.bv; b_rd = v.brd; b_data = v.bd;
        issue_valid = v.iv; issue_rd = v.ird;
    endtask

    task automatic check_out(input string tag, input logic we, input logic [4:0] wa,
                             input logic [31:0] wd, input logic brdy, input logic [31:0] bsy);
        chk({tag, " enable"}, {31'd0, rf_write_enable}, {31'd0, we});
        if (we) begin
            chk({tag, " addr"}, {27'd0, rf_write_address}, {27'd0, wa});
            chk({tag, " data"}, rf_write_data, wd);
        end
        chk({tag, " b_ready"}, {31'd0, b_ready}, {31'd0, brdy});
        chk({tag, " busy"}, busy, bsy);
    endtask

    initial begin
        //          rst av ard   ad            bv brd    bd           iv ird   we wa    wd            rdy busy
        vecs.push_back(mk(1, 1, 5'd4, 32'h44, 1, 5'd6, 32'h66, 1, 5'd8, 0, 5'd0, 32'h0, 1, 32'h0));
        // single ALU write
        vecs.push_back(mk(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        // reserve r7, B result waits behind three ALU writes
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0, 0, 1, 32'h80));
        vecs.push_back(mk(0, 1, 5'd3, 32'h33, 1, 5'd7, 32'h11, 0, 0, 1, 5'd3, 32'h33, 1, 32'h80));
        vecs.push_back(mk(0, 1, 5'd3, 32'h34, 0, 0, 0, 0, 0, 1, 5'd3, 32'h34, 1, 32'h80));
        vecs.push_back(mk(0, 1, 5'd3, 32'h35, 0, 0, 0, 0, 0, 1, 5'd3, 32'h35, 1, 32'h80));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 32'h11, 1, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        // fill the FIFO while ALU holds the port; rejected pushes must not enter
        vecs.push_back(mk(0, 1, 5'd1, 32'hA1, 1, 5'd10, 32'hB0, 0, 0, 1, 5'd1, 32'hA1, 1, 0));
        vecs.push_back(mk(0, 1, 5'd1, 32'hA2, 1, 5'd11, 32'hB1, 0, 0, 1, 5'd1, 32'hA2, 1, 0));
        vecs.push_back(mk(0, 1, 5'd1, 32'hA3, 1, 5'd12, 32'hB2, 0, 0, 1, 5'd1, 32'hA3, 1, 0));
        vecs.push_back(mk(0, 1, 5'd1, 32'hA4, 1, 5'd13, 32'hB3, 0, 0, 1, 5'd1, 32'hA4, 0, 0));
        vecs.push_back(mk(0, 1, 5'd1, 32'hA5, 1, 5'd14, 32'hB4, 0, 0, 1, 5'd1, 32'hA5, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 5'd15, 32'hB5, 0, 0, 1, 5'd10, 32'hB0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd11, 32'hB1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd12, 32'hB2, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd13, 32'hB3, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        // rd=0 from both sources, issue of r0 ignored
        vecs.push_back(mk(0, 1, 5'd0, 32'hFF, 1, 5'd0, 32'hEE, 1, 5'd0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        // re-reserve r9 on the edge its pending result retires
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0, 0, 1, 32'h200));
        vecs.push_back(mk(0, 0, 0, 0, 1, 5'd9, 32'h99, 0, 0, 0, 0, 0, 1, 32'h200));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 1, 5'd9, 32'h99, 1, 32'h200));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200));
        // ALU write to a busy register leaves busy set
        vecs.push_back(mk(0, 1, 5'd9, 32'h9A, 0, 0, 0, 0, 0, 1, 5'd9, 32'h9A, 1, 32'h200));
        // build busy=0x480 with 3 entries buffered, then reset
        vecs.push_back(mk(0, 0, 0, 0, 1, 5'd9, 32'h98, 1, 5'd7, 0, 0, 0, 1, 32'h280));
        vecs.push_back(mk(0, 0, 0, 0, 1, 5'd7, 32'h70, 1, 5'd10, 1, 5'd9, 32'h98, 1, 32'h480));
        vecs.push_back(mk(0, 1, 5'd2, 32'h22, 1, 5'd10, 32'hA0, 0, 0, 1, 5'd2, 32'h22, 1, 32'h480));
        vecs.push_back(mk(0, 1, 5'd2, 32'h23, 1, 5'd1, 32'h01, 0, 0, 1, 5'd2, 32'h23, 1, 32'h480));
        vecs.push_back(mk(1, 1, 5'd4, 32'h44, 1, 5'd5, 32'h55, 1, 5'd6, 0, 0, 0, 1, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 5'd3, 32'h3C, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd3, 32'h3C, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].we, vecs[i].wa, vecs[i].wd,
                      vecs[i].brdy, vecs[i].bsy);
        end

        // Three entries queued, then push and pop together for two cycles: occupancy stays
        // at three and results drain in push order.
        for (int k = 0; k < 3; k++) begin
            drive(mk(0, 1, 5'd1, 32'hC0 + k, 1, 5'(16 + k), 32'h100 + k, 0, 0,
                     0, 0, 0, 0, 0));
            @(posedge clk);
            #1;
            check_out($sformatf("fill%0d", k), 1'b1, 5'd1, 32'hC0 + k, 1'b1, 32'h0);
        end
        for (int k = 0; k < 2; k++) begin
            drive(mk(0, 0, 0, 0, 1, 5'(19 + k), 32'h103 + k, 0, 0, 0, 0, 0, 0, 0));
            @(posedge clk);
            #1;
            check_out($sformatf("pushpop%0d", k), 1'b1, 5'(16 + k), 32'h100 + k, 1'b1, 32'h0);
        end
        for (int k = 0; k < 4; k++) begin
            drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            @(posedge clk);
            #1;
            check_out($sformatf("drain%0d", k), (k < 3), 5'(18 + k), 32'h102 + k, 1'b1, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
